// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default datapath/timeout sizing.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  localparam int FETCH_DW_DEFAULT      = 16;
  localparam int FETCH_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory read per start request, captures
// the returned word into the instruction register, pulses pc_inc once per
// completed fetch and holds the instruction until decode accepts it.
//
// Optional build macro FETCH_TIMEOUT_EN: adds an 8-bit wait counter that
// abandons a read after TIMEOUT cycles without mem_ready and raises a sticky
// fetch_err. Without the macro, REQ waits indefinitely and fetch_err is 0.
//
// Handshake: ir_valid/decode_ready is a valid/ready pair -- the instruction
// transfers on a rising clk edge where both are high; while ir_valid is high
// and decode_ready is low, ir_out is held stable. mem_req is a level request
// that stays high with a stable mem_addr until the edge where mem_ready=1 is
// sampled (or until flush/reset/timeout abandons it).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DW      = FETCH_DW_DEFAULT,
  parameter int TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic [DW-1:0] pc_in,
  output logic [DW-1:0] mem_addr,
  output logic          mem_req,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          pc_inc,
  output logic [DW-1:0] ir_out,
  output logic          ir_valid,
  input  logic          decode_ready,
  output logic          busy,
  output logic          fetch_err,
  output logic [1:0]    dbg_state_o
);

  fetch_state_e  state_q;
  logic [DW-1:0] mem_addr_q;
  logic          mem_req_q;
  logic [DW-1:0] ir_out_q;
  logic          ir_valid_q;
  logic          pc_inc_q;

`ifdef FETCH_TIMEOUT_EN
  // Last count value before giving up; the abandon happens on the edge where
  // the counter has already seen TIMEOUT-1 idle REQ cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_q;
  logic       fetch_err_q;
`endif

  // Fetch FSM with all outputs registered; flush and reset win over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ir_out_q   <= '0;
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      // pc_inc is a single-cycle pulse unless re-armed below.
      pc_inc_q <= 1'b0;
      if (flush) begin
        state_q    <= ST_IDLE;
        mem_req_q  <= 1'b0;
        ir_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q    <= ST_REQ;
              mem_addr_q <= pc_in;
              mem_req_q  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              tmo_cnt_q   <= '0;
              fetch_err_q <= 1'b0;
`endif
            end
          end
          ST_REQ: begin
            if (mem_ready) begin
              state_q    <= ST_VALID;
              ir_out_q   <= mem_rdata;
              ir_valid_q <= 1'b1;
              pc_inc_q   <= 1'b1;
              mem_req_q  <= 1'b0;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
              state_q     <= ST_IDLE;
              mem_req_q   <= 1'b0;
              fetch_err_q <= 1'b1;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
`endif
          end
          ST_VALID: begin
            if (decode_ready) begin
              ir_valid_q <= 1'b0;
              if (start) begin
                // Back-to-back: the PC register has already advanced.
                state_q    <= ST_REQ;
                mem_addr_q <= pc_in;
                mem_req_q  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                tmo_cnt_q   <= '0;
                fetch_err_q <= 1'b0;
`endif
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_req     = mem_req_q;
  assign ir_out      = ir_out_q;
  assign ir_valid    = ir_valid_q;
  assign pc_inc      = pc_inc_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  // No timeout hardware in this build; TIMEOUT only participates so the
  // parameter stays referenced.
  assign fetch_err = 1'b0 && (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Inputs are driven and outputs sampled
// on the falling clock edge. Define FETCH_TIMEOUT_EN to exercise the timeout
// build (TIMEOUT=4).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DW = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic          clk = 1'b0;
  logic          rst, start, flush, mem_ready, decode_ready;
  logic [DW-1:0] pc_in, mem_rdata;
  logic [DW-1:0] mem_addr, ir_out;
  logic          mem_req, pc_inc, ir_valid, busy, fetch_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pc_inc_cnt = 0;
  int fetch_pc0  = 0;
  logic [DW-1:0] exp_q[$];

  fetch_unit #(.DW(DW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc_inc(pc_inc), .ir_out(ir_out),
    .ir_valid(ir_valid), .decode_ready(decode_ready), .busy(busy),
    .fetch_err(fetch_err), .dbg_state_o(dbg_state)
  );

  // Clock and reset-independent monitors
  always #5 clk = ~clk;

  always @(posedge clk) if (pc_inc === 1'b1) pc_inc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: start one fetch at addr, answer after 'delay' idle REQ cycles.
  task automatic do_fetch(input logic [DW-1:0] addr, input logic [DW-1:0] data,
                          input int delay);
    @(negedge clk);
    pc_in = addr; start = 1'b1;
    fetch_pc0 = pc_inc_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < delay; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== addr) begin
        n_fail++;
        $display("FAIL fetch_wait_req: got req=%0b addr=%h want req=1 addr=%h", mem_req, mem_addr, addr);
      end
      @(negedge clk);
    end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== addr) begin
      n_fail++;
      $display("FAIL fetch_req: got req=%0b addr=%h want req=1 addr=%h", mem_req, mem_addr, addr);
    end
    mem_ready = 1'b1; mem_rdata = data;
    exp_q.push_back(data);
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = $urandom_range(0, 65535);
  endtask

  // Consumer: bounded wait for ir_valid, compare with scoreboard, accept.
  task automatic consume(input int hold);
    logic [DW-1:0] exp;
    int waited = 0;
    while (ir_valid !== 1'b1 && waited < 20) begin
      @(negedge clk); waited++;
    end
    n_checks++;
    if (ir_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL consume_valid: got ir_valid=%0b want 1 within 20 cycles", ir_valid);
      return;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (ir_valid !== 1'b1 || ir_out !== exp) begin
        n_fail++;
        $display("FAIL consume_hold: got valid=%0b ir=%h want valid=1 ir=%h", ir_valid, ir_out, exp);
      end
    end
    n_checks++;
    if (ir_out !== exp) begin
      n_fail++;
      $display("FAIL consume_data: got ir_out=%h want %h", ir_out, exp);
    end
    decode_ready = 1'b1;
    @(negedge clk);
    decode_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || busy !== 1'b0 || (pc_inc_cnt - fetch_pc0) != 1) begin
      n_fail++;
      $display("FAIL consume_done: got valid=%0b busy=%0b pc_incs=%0d want 0 0 1", ir_valid, busy, pc_inc_cnt - fetch_pc0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; flush = 0; mem_ready = 0; decode_ready = 0;
    pc_in = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({mem_req, ir_valid, pc_inc, busy, fetch_err} !== 5'b0 || mem_addr !== '0 || ir_out !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: got req=%0b v=%0b inc=%0b busy=%0b err=%0b addr=%h ir=%h st=%0d want all 0",
               mem_req, ir_valid, pc_inc, busy, fetch_err, mem_addr, ir_out, dbg_state);
    end
  endtask

  // Immediate mem_ready: ir_valid and pc_inc appear two edges after start.
  task automatic test_single_fetch();
    @(negedge clk);
    pc_in = 16'h0010; start = 1'b1; fetch_pc0 = pc_inc_cnt;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || ir_valid !== 1'b0 || busy !== 1'b1 || dbg_state !== ST_REQ) begin
      n_fail++;
      $display("FAIL single_req: got req=%0b addr=%h v=%0b busy=%0b st=%0d want 1 0010 0 1 1", mem_req, mem_addr, ir_valid, busy, dbg_state);
    end
    mem_ready = 1'b1; mem_rdata = 16'hA5A5; exp_q.push_back(16'hA5A5);
    @(negedge clk);
    mem_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b1 || pc_inc !== 1'b1 || mem_req !== 1'b0 || dbg_state !== ST_VALID) begin
      n_fail++;
      $display("FAIL single_capture: got v=%0b inc=%0b req=%0b st=%0d want 1 1 0 2", ir_valid, pc_inc, mem_req, dbg_state);
    end
    @(negedge clk);
    n_checks++;
    if (pc_inc !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pc_inc_pulse: got pc_inc=%0b want 0", pc_inc);
    end
    consume(1);
  endtask

  // Delayed mem_ready holds the request stable for 6 cycles.
  task automatic test_delayed_ready();
    do_fetch(16'h1234, 16'h5A5A, 5);
    consume(0);
  endtask

  // start in REQ or in VALID without decode_ready is dropped; stray mem_ready too.
  task automatic test_ignored_inputs();
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || pc_inc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready_ignored: got v=%0b inc=%0b busy=%0b want 0 0 0", ir_valid, pc_inc, busy);
    end
    @(negedge clk);
    pc_in = 16'h0200; start = 1'b1; fetch_pc0 = pc_inc_cnt;
    @(negedge clk);
    pc_in = 16'h0300;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (mem_addr !== 16'h0200 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_start_ignored: got addr=%h req=%0b want 0200 1", mem_addr, mem_req);
    end
    mem_ready = 1'b1; mem_rdata = 16'h0F0F; exp_q.push_back(16'h0F0F);
    @(negedge clk);
    mem_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (dbg_state !== ST_VALID || mem_req !== 1'b0 || ir_out !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL valid_start_ignored: got st=%0d req=%0b ir=%h want 2 0 0f0f", dbg_state, mem_req, ir_out);
    end
    consume(1);
  endtask

  // Accept + start in the same cycle goes straight to REQ.
  task automatic test_back_to_back();
    do_fetch(16'h0010, 16'h1111, 0);
    n_checks++;
    if (ir_valid !== 1'b1 || ir_out !== 16'h1111) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%0b ir=%h want 1 1111", ir_valid, ir_out);
    end
    void'(exp_q.pop_front());
    decode_ready = 1'b1; start = 1'b1; pc_in = 16'h0011;
    @(negedge clk);
    decode_ready = 1'b0; start = 1'b0;
    n_checks++;
    if (dbg_state !== ST_REQ || mem_req !== 1'b1 || mem_addr !== 16'h0011 || ir_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_req: got st=%0d req=%0b addr=%h v=%0b busy=%0b want 1 1 0011 0 1", dbg_state, mem_req, mem_addr, ir_valid, busy);
    end
    fetch_pc0 = pc_inc_cnt;
    mem_ready = 1'b1; mem_rdata = 16'h2222; exp_q.push_back(16'h2222);
    @(negedge clk);
    mem_ready = 1'b0;
    consume(0);
  endtask

  // flush beats a simultaneous mem_ready: no capture, no pc_inc.
  task automatic test_flush();
    int pc0;
    @(negedge clk);
    pc_in = 16'h0400; start = 1'b1; pc0 = pc_inc_cnt;
    @(negedge clk);
    start = 1'b0; flush = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b0;
    n_checks++;
    if (dbg_state !== ST_IDLE || ir_valid !== 1'b0 || mem_req !== 1'b0 || pc_inc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: got st=%0d v=%0b req=%0b inc=%0b busy=%0b want 0 0 0 0 0", dbg_state, ir_valid, mem_req, pc_inc, busy);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (pc_inc_cnt != pc0 || ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_pc_inc: got pc_incs=%0d v=%0b want 0 0", pc_inc_cnt - pc0, ir_valid);
    end
  endtask

  // Reset mid-REQ (with flush) followed by a late mem_ready: nothing captured.
  task automatic test_reset_mid_fetch();
    int pc0;
    @(negedge clk);
    pc_in = 16'h0500; start = 1'b1; pc0 = pc_inc_cnt;
    @(negedge clk);
    start = 1'b0; rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    n_checks++;
    if ({mem_req, ir_valid, pc_inc, busy, fetch_err} !== 5'b0 || mem_addr !== '0 || ir_out !== '0 || pc_inc_cnt != pc0) begin
      n_fail++;
      $display("FAIL rst_mid_fetch: got req=%0b v=%0b inc=%0b busy=%0b err=%0b addr=%h ir=%h incs=%0d want all 0",
               mem_req, ir_valid, pc_inc, busy, fetch_err, mem_addr, ir_out, pc_inc_cnt - pc0);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  // No mem_ready: request dropped after 4 cycles, sticky error until next start.
  task automatic test_timeout();
    int pc0;
    @(negedge clk);
    pc_in = 16'h0600; start = 1'b1; pc0 = pc_inc_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait[%0d]: got req=%0b err=%0b want 1 0", i, mem_req, fetch_err);
      end
      @(negedge clk);
    end
    n_checks++;
    if (mem_req !== 1'b0 || fetch_err !== 1'b1 || busy !== 1'b0 || pc_inc_cnt != pc0) begin
      n_fail++;
      $display("FAIL timeout_fire: got req=%0b err=%0b busy=%0b incs=%0d want 0 1 0 0", mem_req, fetch_err, busy, pc_inc_cnt - pc0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (fetch_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err=%0b want 1", fetch_err);
    end
    do_fetch(16'h0700, 16'h7777, 1);
    n_checks++;
    if (fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got err=%0b want 0", fetch_err);
    end
    consume(0);
  endtask
`else
  // No timeout hardware: REQ waits as long as it takes.
  task automatic test_no_timeout();
    do_fetch(16'h0600, 16'h6666, 300);
    n_checks++;
    if (fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_err: got err=%0b want 0", fetch_err);
    end
    consume(0);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      do_fetch(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               int'($urandom_range(0, 3)));
      consume(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_delayed_ready();
    test_ignored_inputs();
    test_back_to_back();
    test_flush();
    test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DW, 16, width of the instruction and address datapath.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles spent waiting for mem_ready (used only with FETCH_TIMEOUT_EN).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: start  input  1  request one instruction fetch.
REQ-006 Port: flush  input  1  abandon any fetch in progress.
REQ-007 Port: pc_in  input  DW  current program-counter value from the upstream PC register.
REQ-008 Port: mem_addr  output  DW  memory read address.
REQ-009 Port: mem_req  output  1  memory read request, level.
REQ-010 Port: mem_rdata  input  DW  memory read data, valid when mem_ready=1.
REQ-011 Port: mem_ready  input  1  memory read completion strobe.
REQ-012 Port: pc_inc  output  1  one-cycle pulse driving the PC register inc input.
REQ-013 Port: ir_out  output  DW  fetched instruction register.
REQ-014 Port: ir_valid  output  1  ir_out holds an unconsumed instruction.
REQ-015 Port: decode_ready  input  1  downstream decode accepts ir_out.
REQ-016 Port: busy  output  1  high whenever state is not IDLE.
REQ-017 Port: fetch_err  output  1  timeout flag; constant 0 without FETCH_TIMEOUT_EN.

Function
REQ-018 FSM states: IDLE, REQ, VALID.
REQ-019 IDLE: start=1 -> REQ next cycle; mem_addr <= pc_in captured on that edge.
REQ-020 REQ: mem_req=1, mem_addr held stable until exit.
REQ-021 REQ with mem_ready=1 -> ir_out <= mem_rdata, ir_valid <= 1, pc_inc=1 for exactly the following cycle, state -> VALID.
REQ-022 Fetch latency: with mem_ready high on the first REQ cycle, ir_valid rises 2 cycles after start is sampled.
REQ-023 VALID: ir_valid=1 and ir_out stable until decode_ready=1 is sampled.
REQ-024 VALID, decode_ready=1, start=0 -> IDLE, ir_valid <= 0.
REQ-025 VALID, decode_ready=1, start=1 -> REQ directly (back-to-back); mem_addr <= pc_in (already incremented by the PC register).
REQ-026 start is ignored in REQ and in VALID without decode_ready; start is not queued.
REQ-027 flush=1 in any state -> IDLE next cycle, mem_req <= 0, ir_valid <= 0, no pc_inc; flush overrides mem_ready, start and decode_ready sampled in the same cycle.
REQ-028 pc_inc never asserts for more than one cycle per completed fetch; mem_ready outside REQ is ignored.
REQ-029 Address arithmetic is the PC register's responsibility; this block performs no address increment; 0xFFFF wraps to 0x0000 upstream.

Reset
REQ-030 rst=1 -> state IDLE, mem_req=0, mem_addr=0, ir_out=0, ir_valid=0, pc_inc=0, busy=0, fetch_err=0, timeout counter=0; rst has priority over flush and all other inputs.
REQ-031 rst asserted mid-fetch discards the outstanding request; a late mem_ready after reset is ignored.

Configuration
REQ-032 Macro FETCH_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each REQ cycle with mem_ready=0; reaching TIMEOUT -> IDLE, mem_req <= 0, fetch_err <= 1 (sticky until rst or the next accepted start), no pc_inc.
REQ-033 Macro FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; fetch_err tied to 0.

Structure
REQ-034 Package fetch_pkg holds the state enumeration typedef, the default DW, and the default TIMEOUT constant.
REQ-035 Single module, no sub-modules; the timeout counter is inline and guarded by the macro.

Verification
REQ-036 pc_in=0x0010, start pulse, mem_ready=1 on the first REQ cycle with rdata=0xA5A5 -> mem_addr=0x0010, ir_out=0xA5A5, ir_valid 2 cycles after start, single pc_inc pulse.
REQ-037 mem_ready delayed 5 cycles -> mem_req held 6 cycles with mem_addr stable, then normal capture and one pc_inc.
REQ-038 VALID with decode_ready=1, start=1, pc_in=0x0011 -> immediate REQ with mem_addr=0x0011 and no IDLE cycle.
REQ-039 flush asserted in REQ in the same cycle as mem_ready=1 -> IDLE, ir_valid=0, pc_inc never asserted.
REQ-040 rst mid-REQ followed by mem_ready=1 -> all outputs at reset values, no capture.
REQ-041 FETCH_TIMEOUT_EN defined, TIMEOUT=4, mem_ready never asserted -> mem_req drops after 4 cycles, fetch_err=1 until the next start.
